univ_shift_reg: RTL and testbench

//   Parametrised successor to the single-bit enabled D flip-flop: a WIDTH-bit register with

---
 rtl/univ_shift_reg.sv | 99 +++++++++
 tb/tb_univ_shift_reg.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register with eight modes and a saturating
// count of bit positions shifted out since the last load, clear or reset.
module univ_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [2:0]                 mode,
  input  logic                       sin_l,
  input  logic                       sin_r,
  input  logic [WIDTH-1:0]           d,
  output logic [WIDTH-1:0]           q,
  output logic                       sout_msb,
  output logic                       sout_lsb,
  output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
  output logic                       drained
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHL  = 3'b001;
  localparam logic [2:0] M_SHR  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic             drained_q, drained_d;

  // count sticks at WIDTH once the register has fully drained
  assign cnt_inc = (cnt_q == FULL) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    q_d   = q_q;
    cnt_d = cnt_q;
    if (en) begin
      unique case (mode)
        M_HOLD: begin
        end
        M_SHL: begin
          q_d   = {q_q[WIDTH-2:0], sin_r};
          cnt_d = cnt_inc;
        end
        M_SHR: begin
          q_d   = {sin_l, q_q[WIDTH-1:1]};
          cnt_d = cnt_inc;
        end
        M_LOAD: begin
          q_d   = d;
          cnt_d = '0;
        end
        M_ROL: begin
          q_d   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          cnt_d = cnt_inc;
        end
        M_ROR: begin
          q_d   = {q_q[0], q_q[WIDTH-1:1]};
          cnt_d = cnt_inc;
        end
        M_ASR: begin
          q_d   = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
          cnt_d = cnt_inc;
        end
        M_CLR: begin
          q_d   = '0;
          cnt_d = '0;
        end
      endcase
    end
  end

  assign drained_d = (cnt_d == FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q       <= RESET_VAL;
      cnt_q     <= '0;
      drained_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      drained_q <= drained_d;
    end
  end

  assign q         = q_q;
  assign sout_msb  = q_q[WIDTH-1];
  assign sout_lsb  = q_q[0];
  assign shift_cnt = cnt_q;
  assign drained   = drained_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed table-driven bench for univ_shift_reg (WIDTH=8, RESET_VAL=0)
// plus hand sequences for reset-mid-shift and serial-out bits.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       reset, en, sin_l, sin_r;
  logic [2:0] mode;
  logic [7:0] d, q;
  logic       sout_msb, sout_lsb, drained;
  logic [3:0] shift_cnt;

  int n_chk = 0;
  int n_err = 0;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .sin_l(sin_l), .sin_r(sin_r), .d(d), .q(q),
    .sout_msb(sout_msb), .sout_lsb(sout_lsb),
    .shift_cnt(shift_cnt), .drained(drained)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic       sl;
    logic       sr;
    logic [7:0] d;
    logic [7:0] eq;
    logic [3:0] ecnt;
    logic       edr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic e, input logic [2:0] m,
                     input logic sl, input logic sr, input logic [7:0] dd,
                     input logic [7:0] eq, input logic [3:0] ec,
                     input logic ed);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.sl = sl; v.sr = sr; v.d = dd;
    v.eq = eq; v.ecnt = ec; v.edr = ed;
    vq.push_back(v);
  endtask

  task automatic check(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic sl, input logic sr, input logic [7:0] dd);
    @(negedge clk);
    reset = r; en = e; mode = m; sin_l = sl; sin_r = sr; d = dd;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] eq,
                           input logic [3:0] ec, input logic ed);
    check({tag, " q"}, q, eq);
    check({tag, " cnt"}, {4'h0, shift_cnt}, {4'h0, ec});
    check({tag, " drained"}, {7'h0, drained}, {7'h0, ed});
    check({tag, " sout_msb"}, {7'h0, sout_msb}, {7'h0, eq[7]});
    check({tag, " sout_lsb"}, {7'h0, sout_lsb}, {7'h0, eq[0]});
  endtask

  initial begin
    logic [7:0] rol_exp[8];
    logic [7:0] shl_exp[8];
    rol_exp = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
    shl_exp = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

    reset = 1'b1; en = 1'b0; mode = 3'd0;
    sin_l = 1'b0; sin_r = 1'b0; d = 8'h00;

    // reset with en and LOAD present
    add(1, 1, 3'd3, 0, 0, 8'hFF, 8'h00, 0, 0);
    add(1, 1, 3'd3, 0, 0, 8'hFF, 8'h00, 0, 0);
    // LOAD then disabled SHL
    add(0, 1, 3'd3, 0, 0, 8'hA5, 8'hA5, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 3'd1, 1, 1, 8'h00, 8'hA5, 0, 0);
    // 8 rotates return to start
    add(0, 1, 3'd3, 0, 0, 8'h81, 8'h81, 0, 0);
    for (int i = 0; i < 8; i++)
      add(0, 1, 3'd4, 1, 0, 8'h00, rol_exp[i], 4'(i + 1), i == 7);
    // ASR and SHR
    add(0, 1, 3'd3, 0, 0, 8'h90, 8'h90, 0, 0);
    add(0, 1, 3'd6, 0, 1, 8'h00, 8'hC8, 1, 0);
    add(0, 1, 3'd6, 0, 1, 8'h00, 8'hE4, 2, 0);
    add(0, 1, 3'd3, 0, 0, 8'h90, 8'h90, 0, 0);
    add(0, 1, 3'd2, 0, 1, 8'h00, 8'h48, 1, 0);
    // SHL saturation
    add(0, 1, 3'd3, 0, 0, 8'h00, 8'h00, 0, 0);
    for (int i = 0; i < 10; i++)
      add(0, 1, 3'd1, 0, 1, 8'h55,
          (i < 8) ? shl_exp[i] : 8'hFF, (i < 8) ? 4'(i + 1) : 4'd8, i >= 7);
    add(0, 1, 3'd3, 1, 1, 8'h3C, 8'h3C, 0, 0);
    add(0, 1, 3'd0, 1, 1, 8'hFF, 8'h3C, 0, 0);
    add(0, 1, 3'd5, 0, 0, 8'h00, 8'h1E, 1, 0);
    add(0, 1, 3'd7, 1, 1, 8'hFF, 8'h00, 0, 0);
    add(0, 1, 3'd2, 1, 0, 8'h00, 8'h80, 1, 0);
    // mode change with en low
    add(0, 0, 3'd7, 0, 0, 8'h00, 8'h80, 1, 0);
    add(0, 0, 3'd3, 0, 0, 8'h77, 8'h80, 1, 0);

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].en, vq[i].mode, vq[i].sl, vq[i].sr, vq[i].d);
      check_all($sformatf("vec%0d", i), vq[i].eq, vq[i].ecnt, vq[i].edr);
    end

    // reset in the middle of a shift run
    step(0, 1, 3'd3, 0, 0, 8'h5A);
    step(0, 1, 3'd1, 0, 0, 8'h00);
    step(0, 1, 3'd1, 0, 0, 8'h00);
    step(0, 1, 3'd1, 0, 0, 8'h00);
    step(0, 1, 3'd1, 0, 0, 8'h00);
    step(0, 1, 3'd1, 0, 0, 8'h00);
    check_all("shl5", 8'h40, 5, 0);
    step(1, 1, 3'd1, 1, 1, 8'hFF);
    check_all("midrst", 8'h00, 0, 0);
    step(0, 1, 3'd1, 0, 1, 8'h00);
    check_all("resume", 8'h01, 1, 0);

    // drained cleared by reset after saturation
    for (int i = 0; i < 8; i++) step(0, 1, 3'd5, 0, 0, 8'h00);
    check_all("ror8", 8'h01, 8, 1);
    step(1, 0, 3'd0, 0, 0, 8'h00);
    check_all("rst_drained", 8'h00, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
